fifo_packet_tx: RTL and testbench

//  Read-side partner of the packet FIFO. Pops packets from the FIFO whenever it is non-empty.

---
 rtl/fifo_packet_tx_pkg.sv | 21 ++
 rtl/fifo_packet_tx_if.sv | 45 ++++
 rtl/fifo_packet_tx_shift_reg.sv | 31 +++
 rtl/fifo_packet_tx.sv | 103 ++++++++++
 tb/tb_fifo_packet_tx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_packet_tx_pkg.sv
// Shared types and defaults for the packet FIFO read-side transmitter.
// Imported by the link interface, the shift register and the top.
package fifo_packet_tx_pkg;

    localparam int PACKET_WIDTH_DEF = 40;
    localparam int FLIT_WIDTH_DEF   = 8;
    localparam int CNT_WIDTH_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SEND  = 2'd3
    } tx_state_t;

    // A single-flit packet still needs a one-bit beat counter.
    function automatic int beat_width(input int nflits);
        return (nflits > 1) ? $clog2(nflits) : 1;
    endfunction

endpackage

// File: rtl/fifo_packet_tx_if.sv
// FIFO read-side and flit link signals of the packet transmitter.
// The master modport is the transmitter; the slave modport is the FIFO/receiver side.
interface fifo_packet_tx_if
    import fifo_packet_tx_pkg::*;
#(
    parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
    parameter int FLIT_WIDTH   = FLIT_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
);

    logic                    o_read_packet_en;
    logic [PACKET_WIDTH-1:0] i_read_packet;
    logic                    i_empty_flag;
    logic [FLIT_WIDTH-1:0]   o_flit;
    logic                    o_flit_valid;
    logic                    o_flit_last;
    logic                    i_flit_ready;
    logic                    o_busy;
    logic [CNT_WIDTH-1:0]    o_pkt_count;

    modport master (
        output o_read_packet_en,
        input  i_read_packet,
        input  i_empty_flag,
        output o_flit,
        output o_flit_valid,
        output o_flit_last,
        input  i_flit_ready,
        output o_busy,
        output o_pkt_count
    );

    modport slave (
        input  o_read_packet_en,
        output i_read_packet,
        output i_empty_flag,
        input  o_flit,
        input  o_flit_valid,
        input  o_flit_last,
        output i_flit_ready,
        input  o_busy,
        input  o_pkt_count
    );

endinterface

// File: rtl/fifo_packet_tx_shift_reg.sv
// Packet shift register: parallel load of a whole packet, then shifts right by one flit per enable.
// The low flit is always the one currently presented on the link.
module flit_shift_reg
    import fifo_packet_tx_pkg::*;
#(
    parameter int WIDTH = PACKET_WIDTH_DEF,
    parameter int SHIFT = FLIT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic [SHIFT-1:0] flit
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift) begin
            shreg <= shreg >> SHIFT;
        end
    end

    assign flit = shreg[SHIFT-1:0];

endmodule

// File: rtl/fifo_packet_tx.sv
// Read-side partner of the packet FIFO: pops packets, serializes them LSB flit first
// onto a valid/ready link and counts packets fully transmitted.
module fifo_packet_tx
    import fifo_packet_tx_pkg::*;
#(
    parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
    parameter int FLIT_WIDTH   = FLIT_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    fifo_packet_tx_if.master bus
);

    localparam int NFLITS     = PACKET_WIDTH / FLIT_WIDTH;
    localparam int BEAT_WIDTH = beat_width(NFLITS);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(NFLITS - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [BEAT_WIDTH-1:0] beat;
    logic [CNT_WIDTH-1:0]  pkt_count;
    logic [FLIT_WIDTH-1:0] head_flit;
    logic                  last_beat;
    logic                  xfer;
    logic                  load;

    assign last_beat = (beat == LAST_BEAT);
    assign xfer      = (state == ST_SEND) && bus.i_flit_ready;
    assign load      = (state == ST_LOAD);

    flit_shift_reg #(
        .WIDTH (PACKET_WIDTH),
        .SHIFT (FLIT_WIDTH)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (xfer),
        .data  (bus.i_read_packet),
        .flit  (head_flit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Empty is rechecked in FETCH so a FIFO that drained meanwhile is never popped.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!bus.i_empty_flag) state_next = ST_FETCH;
            ST_FETCH: state_next = bus.i_empty_flag ? ST_IDLE : ST_LOAD;
            ST_LOAD:  state_next = ST_SEND;
            ST_SEND: begin
                if (xfer && last_beat) begin
                    state_next = bus.i_empty_flag ? ST_IDLE : ST_FETCH;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_read_packet_en = 1'b0;
        bus.o_flit           = '0;
        bus.o_flit_valid     = 1'b0;
        bus.o_flit_last      = 1'b0;
        bus.o_busy           = (state != ST_IDLE);
        bus.o_pkt_count      = pkt_count;
        case (state)
            ST_FETCH: bus.o_read_packet_en = !bus.i_empty_flag;
            ST_SEND: begin
                bus.o_flit_valid = 1'b1;
                bus.o_flit       = head_flit;
                bus.o_flit_last  = last_beat;
            end
            default: ;
        endcase
    end

    // The beat counter restarts on every load, so its wrap after the last flit is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= '0;
            pkt_count <= '0;
        end else begin
            if (load) begin
                beat <= '0;
            end else if (xfer) begin
                beat <= beat + 1'b1;
            end
            if (xfer && last_beat) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_packet_tx.sv
// Directed bench for fifo_packet_tx: a 32x40 FIFO model feeds the main instance,
// a second instance with a 2-bit counter exercises counter wrap and the FETCH empty recheck.
module tb_fifo_packet_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_packet_tx_if #(.PACKET_WIDTH(40), .FLIT_WIDTH(8), .CNT_WIDTH(16)) m_if ();
    fifo_packet_tx_if #(.PACKET_WIDTH(40), .FLIT_WIDTH(8), .CNT_WIDTH(2))  w_if ();

    fifo_packet_tx #(.PACKET_WIDTH(40), .FLIT_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    fifo_packet_tx #(.PACKET_WIDTH(40), .FLIT_WIDTH(8), .CNT_WIDTH(2)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (w_if)
    );

    int checks = 0;
    int errors = 0;

    logic        ready   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [39:0] wr_data = '0;
    logic        w_empty = 1'b1;

    // FIFO model (depth 32, registered read data valid the cycle after a pop).
    logic [39:0] fifo_mem [0:31];
    logic [4:0]  wr_ptr     = '0;
    logic [4:0]  rd_ptr     = '0;
    logic [5:0]  fifo_count = '0;
    logic [39:0] fifo_rdata = '0;
    int          pop_empty_errors = 0;

    always @(posedge clk) begin
        if (wr_en && fifo_count != 6'd32) begin
            fifo_mem[wr_ptr] <= wr_data;
            wr_ptr <= wr_ptr + 5'd1;
        end
        if (m_if.o_read_packet_en) begin
            if (fifo_count == 6'd0) begin
                pop_empty_errors <= pop_empty_errors + 1;
            end else begin
                fifo_rdata <= fifo_mem[rd_ptr];
                rd_ptr <= rd_ptr + 5'd1;
            end
        end
        fifo_count <= fifo_count + 6'(wr_en && fifo_count != 6'd32)
                                 - 6'(m_if.o_read_packet_en && fifo_count != 6'd0);
    end

    assign m_if.i_empty_flag  = (fifo_count == 6'd0);
    assign m_if.i_read_packet = fifo_rdata;
    assign m_if.i_flit_ready  = ready;

    assign w_if.i_empty_flag  = w_empty;
    assign w_if.i_read_packet = 40'h04_03_02_01_00;
    assign w_if.i_flit_ready  = 1'b1;

    // All tasks start and end on a falling edge.
    task automatic push(input logic [39:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
    task automatic collect_packet(input int mode, input int budget,
                                  output logic [39:0] data, output logic [4:0] lasts,
                                  output int unstable, output int idle, output bit done);
        int beat = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [7:0] hflit = '0;
        logic hlast = 1'b0;
        data = '0;
        lasts = '0;
        unstable = 0;
        idle = 0;
        while (beat < 5 && cyc < budget) begin
            ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (held && (m_if.o_flit_valid !== 1'b1 || m_if.o_flit !== hflit ||
                         m_if.o_flit_last !== hlast)) begin
                unstable++;
            end
            if (m_if.o_flit_valid !== 1'b1) begin
                idle++;
            end else if (ready) begin
                data[beat*8 +: 8] = m_if.o_flit;
                lasts[beat] = m_if.o_flit_last;
                beat++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                hflit = m_if.o_flit;
                hlast = m_if.o_flit_last;
            end
            @(negedge clk);
            cyc++;
        end
        done = (beat == 5);
    endtask

    function automatic logic [39:0] burst_pkt(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic test_reset();
        int pops = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_if.o_read_packet_en, m_if.o_flit, m_if.o_flit_valid, m_if.o_flit_last,
             m_if.o_busy, m_if.o_pkt_count} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got en=%b flit=%h v=%b l=%b busy=%b cnt=%0d, required all 0",
                     m_if.o_read_packet_en, m_if.o_flit, m_if.o_flit_valid, m_if.o_flit_last,
                     m_if.o_busy, m_if.o_pkt_count);
        end
        checks++;
        if ({w_if.o_read_packet_en, w_if.o_flit_valid, w_if.o_busy, w_if.o_pkt_count} !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_wrap_outputs: got en=%b v=%b busy=%b cnt=%0d, required all 0",
                     w_if.o_read_packet_en, w_if.o_flit_valid, w_if.o_busy, w_if.o_pkt_count);
        end
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (m_if.o_read_packet_en !== 1'b0 || m_if.o_busy !== 1'b0) pops++;
            @(negedge clk);
        end
        checks++;
        if (pops != 0) begin
            errors++;
            $display("[TB] FAIL idle_empty: got %0d cycles with pop/busy, required 0", pops);
        end
    endtask

    task automatic test_single();
        logic [39:0] d;
        logic [4:0] l;
        int u, idle;
        bit ok;
        ready = 1'b1;
        push(40'h44_33_22_11_00);
        checks++;
        if (m_if.o_read_packet_en !== 1'b0 || m_if.o_flit_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_t0: got en=%b valid=%b, required 0 0",
                     m_if.o_read_packet_en, m_if.o_flit_valid);
        end
        @(negedge clk);
        checks++;
        if (m_if.o_read_packet_en !== 1'b1 || m_if.o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_pop: got en=%b busy=%b, required 1 1",
                     m_if.o_read_packet_en, m_if.o_busy);
        end
        @(negedge clk);
        checks++;
        if (m_if.o_read_packet_en !== 1'b0 || m_if.o_flit_valid !== 1'b0 || m_if.o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_cycle: got en=%b valid=%b busy=%b, required 0 0 1",
                     m_if.o_read_packet_en, m_if.o_flit_valid, m_if.o_busy);
        end
        @(negedge clk);
        checks++;
        if (m_if.o_flit_valid !== 1'b1 || m_if.o_flit !== 8'h00) begin
            errors++;
            $display("[TB] FAIL first_flit_t3: got valid=%b flit=%h, required 1 00",
                     m_if.o_flit_valid, m_if.o_flit);
        end
        collect_packet(0, 20, d, l, u, idle, ok);
        checks++;
        if (!ok || d !== 40'h44_33_22_11_00) begin
            errors++;
            $display("[TB] FAIL single_data: got %h done=%b, required 4433221100", d, ok);
        end
        checks++;
        if (l !== 5'b10000 || idle != 0) begin
            errors++;
            $display("[TB] FAIL single_last: got last=%b gaps=%0d, required 10000 0", l, idle);
        end
        checks++;
        if (m_if.o_pkt_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d, required 1", m_if.o_pkt_count);
        end
    endtask

    task automatic test_backpressure();
        logic [39:0] d;
        logic [4:0] l;
        int u, idle;
        int extra = 0;
        bit ok;
        ready = 1'b1;
        push(40'h44_33_22_11_00);
        collect_packet(1, 40, d, l, u, idle, ok);
        checks++;
        if (!ok || d !== 40'h44_33_22_11_00 || l !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL bp_data: got %h last=%b done=%b, required 4433221100 10000 1", d, l, ok);
        end
        checks++;
        if (u != 0) begin
            errors++;
            $display("[TB] FAIL bp_hold_stable: got %0d unstable cycles, required 0", u);
        end
        for (int n = 0; n < 4; n++) begin
            if (m_if.o_flit_valid !== 1'b0) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0 || m_if.o_pkt_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL bp_exact_five: got extra=%0d count=%0d, required 0 2",
                     extra, m_if.o_pkt_count);
        end
    endtask

    task automatic test_burst();
        logic [39:0] d;
        logic [4:0] l;
        int u, idle;
        bit ok;
        ready = 1'b0;
        for (int i = 0; i < 32; i++) push(burst_pkt(i));
        for (int i = 0; i < 32; i++) begin
            collect_packet(0, 50, d, l, u, idle, ok);
            checks++;
            if (!ok || d !== burst_pkt(i) || l !== 5'b10000) begin
                errors++;
                $display("[TB] FAIL burst_pkt%0d: got %h last=%b done=%b, required %h 10000 1",
                         i, d, l, ok, burst_pkt(i));
            end
            if (i > 0) begin
                checks++;
                if (idle != 2) begin
                    errors++;
                    $display("[TB] FAIL burst_gap%0d: got %0d idle cycles, required 2", i, idle);
                end
            end
        end
        checks++;
        if (m_if.o_pkt_count !== 16'd34 || pop_empty_errors != 0) begin
            errors++;
            $display("[TB] FAIL burst_count: got count=%0d empty_pops=%0d, required 34 0",
                     m_if.o_pkt_count, pop_empty_errors);
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] d;
        logic [4:0] l;
        int u, idle;
        int n = 0;
        int resent = 0;
        bit ok;
        ready = 1'b1;
        push(40'h5A_4A_3A_2A_1A);
        while (m_if.o_flit_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_if.o_flit_valid !== 1'b1 || m_if.o_flit !== 8'h1A) begin
            errors++;
            $display("[TB] FAIL mid_flit0: got valid=%b flit=%h, required 1 1a",
                     m_if.o_flit_valid, m_if.o_flit);
        end
        @(negedge clk);
        checks++;
        if (m_if.o_flit !== 8'h2A) begin
            errors++;
            $display("[TB] FAIL mid_flit1: got %h, required 2a", m_if.o_flit);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_if.o_read_packet_en, m_if.o_flit, m_if.o_flit_valid, m_if.o_flit_last,
             m_if.o_busy, m_if.o_pkt_count} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got flit=%h v=%b busy=%b cnt=%0d, required all 0",
                     m_if.o_flit, m_if.o_flit_valid, m_if.o_busy, m_if.o_pkt_count);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (m_if.o_flit_valid !== 1'b0 || m_if.o_read_packet_en !== 1'b0) resent++;
            @(negedge clk);
        end
        checks++;
        if (resent != 0) begin
            errors++;
            $display("[TB] FAIL mid_not_resent: got %0d active cycles, required 0", resent);
        end
        push(40'hE5_D4_C3_B2_A1);
        collect_packet(0, 20, d, l, u, idle, ok);
        checks++;
        if (!ok || d !== 40'hE5_D4_C3_B2_A1 || l !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL mid_packet_b: got %h last=%b done=%b, required e5d4c3b2a1 10000 1",
                     d, l, ok);
        end
        checks++;
        if (m_if.o_pkt_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL mid_count: got %0d, required 1", m_if.o_pkt_count);
        end
    endtask

    task automatic test_fetch_recheck();
        w_empty = 1'b0;
        @(negedge clk);
        w_empty = 1'b1;
        #1;
        checks++;
        if (w_if.o_read_packet_en !== 1'b0 || w_if.o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_recheck: got en=%b busy=%b, required 0 1",
                     w_if.o_read_packet_en, w_if.o_busy);
        end
        @(negedge clk);
        checks++;
        if (w_if.o_busy !== 1'b0 || w_if.o_flit_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_to_idle: got busy=%b valid=%b, required 0 0",
                     w_if.o_busy, w_if.o_flit_valid);
        end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        w_empty = 1'b0;
        for (int k = 0; k < 5; k++) begin
            int n = 0;
            while (!(w_if.o_flit_valid === 1'b1 && w_if.o_flit_last === 1'b1) && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (k == 4) w_empty = 1'b1;
            @(negedge clk);
            checks++;
            if (w_if.o_pkt_count !== exp_seq[k]) begin
                errors++;
                $display("[TB] FAIL wrap_count%0d: got %0d, required %0d", k, w_if.o_pkt_count, exp_seq[k]);
            end
        end
        checks++;
        if (w_if.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_idle: got busy=%b, required 0", w_if.o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_burst();
        test_reset_mid();
        test_fetch_recheck();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
